fixed_deparser: RTL and testbench
=================================

Name: fixed_deparser

Overview:
- Transmit-side counterpart of the fixed header parser.
- Takes a captured header byte array and the per-header offset vector (`NO_HEADER` marks an absent header).
- Re-serializes the present headers, in header order, into a byte stream with valid/ready flow control. The stream feeds the egress packet assembler.
- Header lengths are fixed per slot: slot 0 Ethernet, slot 1 IPv4, slot 2 L4.

Parameters:
- HDR0_LEN, 14, byte length of header slot 0 (Ethernet).
- HDR1_LEN, 20, byte length of header slot 1 (IPv4, no options).
- HDR2_LEN, 8, byte length of header slot 2 (UDP).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset (`TRUE = asserted).
- start_i  input  1  request to deparse; sampled only in STATE_FREE.
- pkt_hdr_i  input  `BYTE_BUS x `HDR_MAX_LEN  header bytes, index 0 = first wire byte.
- hdrs_i  input  `DATA_BUS x `NUM_HEADERS  byte offset of each header slot, or `NO_HEADER.
- byte_o  output  `BYTE_BUS  current output byte.
- valid_o  output  1  byte_o valid.
- last_o  output  1  byte_o is the final byte of this packet's headers.
- ready_i  input  1  downstream accepts byte_o this cycle.
- busy_o  output  1  high from accepted start until done.
- done_o  output  1  one-cycle pulse at completion.
- err_o  output  1  at least one header slot skipped as out of bounds; held until the next accepted start.

Behaviour:
- Reset values: byte_o=0, valid_o=`FALSE, last_o=`FALSE, busy_o=`FALSE, done_o=`FALSE, err_o=`FALSE, state=STATE_FREE.
- Reset applies on the next posedge from any state; an in-flight packet is abandoned and no done_o is issued.
- Transfer rule: a byte moves only in a cycle with valid_o && ready_i.
  - While valid_o=1 and ready_i=0, byte_o and last_o hold stable.
  - valid_o never drops without a transfer.
- STATE_FREE:
  - On start_i=`TRUE, latch pkt_hdr_i and hdrs_i into internal registers.
  - Clear err_o, set busy_o.
  - Evaluate each slot k: present = (off_k != `NO_HEADER) && (off_k + LEN_k <= `HDR_MAX_LEN).
  - If off_k != `NO_HEADER but out of bounds, set err_o and treat the slot as absent.
  - Go to STATE_EMIT if any slot is present, else to STATE_DONE.
  - Later changes on the inputs have no effect on the packet in flight.
- STATE_EMIT:
  - Registers: slot index k (lowest present slot first) and byte counter i (0..LEN_k-1).
  - Drive byte_o = latched_hdr[off_k + i] and valid_o=1.
  - First byte is valid on the cycle after start is accepted.
  - On each transfer, i increments. At i = LEN_k-1, advance to the next present slot with i=0; absent slots are skipped with no bubble.
  - last_o=1 exactly on the final byte of the highest present slot.
  - On the transfer of that byte, go to STATE_DONE with valid_o=0.
- STATE_DONE: one cycle. done_o=1, busy_o=0, then STATE_FREE.
- Back-to-back: start_i may be accepted on the cycle after done_o; the minimum gap between packets is 2 cycles of no valid output.
- start_i while busy_o=1 is ignored, with no queuing.
- Overlapping headers are emitted as indexed, with no overlap check.
- Offset arithmetic is done at `DATA_BUS width plus 1 bit so the bound check cannot wrap.
- Bytes per packet = sum of LEN_k over present slots. Maximum is 42, minimum is 0.
- Zero-byte packet (all slots absent): valid_o never asserts, and done_o pulses 2 cycles after the start cycle.

Test Plan:
- IPv4 packet: hdrs_i={0,14,`NO_HEADER}, ready_i=1, start at cycle T.
  - valid_o at T+1 through T+34 (34 bytes), byte_o = pkt_hdr_i[0..33] in order.
  - last_o only at T+34; done_o at T+35.
- Non-IP packet: hdrs_i={0,`NO_HEADER,`NO_HEADER} -> exactly 14 bytes, last_o on byte 13, err_o=0.
- Backpressure: IPv4+UDP at offsets {0,14,34}, ready_i toggling 1,0,0,1,...
  - 42 bytes in order, byte_o/last_o stable during stalls, no byte duplicated or dropped.
- Out of bounds: hdrs_i[1] = `HDR_MAX_LEN-10 -> slot 1 skipped, err_o=1, only 14 bytes emitted.
  - err_o clears on the next accepted start.
- Edge starts:
  - All slots `NO_HEADER -> no valid_o, done_o 2 cycles after start.
  - start_i pulsed mid-emission -> ignored, byte count unchanged.
- Reset mid-packet: rst=1 after byte 5 -> next cycle all outputs at reset values.
  - A new start then emits from byte 0 of the new packet.

Source files
------------

// File: rtl/fixed_deparser_if.sv
// Header deparser port bundle: deparse request, header capture and the
// outgoing byte stream with valid/ready flow control.
`ifndef FIXED_DEPARSER_DEFS
`define FIXED_DEPARSER_DEFS
`define TRUE        1'b1
`define FALSE       1'b0
`define BYTE_BUS    8
`define DATA_BUS    8
`define HDR_MAX_LEN 64
`define NUM_HEADERS 3
`define NO_HEADER   8'hFF
`endif

interface fixed_deparser_if;
  logic                                     start_i;
  logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0]   pkt_hdr_i;
  logic [`NUM_HEADERS-1:0][`DATA_BUS-1:0]   hdrs_i;
  logic [`BYTE_BUS-1:0]                     byte_o;
  logic                                     valid_o;
  logic                                     last_o;
  logic                                     ready_i;
  logic                                     busy_o;
  logic                                     done_o;
  logic                                     err_o;

  // Deparser side: sources the byte stream.
  modport master (
    input  start_i, pkt_hdr_i, hdrs_i, ready_i,
    output byte_o, valid_o, last_o, busy_o, done_o, err_o
  );

  // Requester / stream consumer side.
  modport slave (
    output start_i, pkt_hdr_i, hdrs_i, ready_i,
    input  byte_o, valid_o, last_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/fixed_deparser.sv
// Fixed header deparser: re-serializes the present header slots of a
// captured header array, lowest slot first, into a valid/ready byte stream.
`ifndef FIXED_DEPARSER_DEFS
`define FIXED_DEPARSER_DEFS
`define TRUE        1'b1
`define FALSE       1'b0
`define BYTE_BUS    8
`define DATA_BUS    8
`define HDR_MAX_LEN 64
`define NUM_HEADERS 3
`define NO_HEADER   8'hFF
`endif

module fixed_deparser #(
  parameter int HDR0_LEN = 14,
  parameter int HDR1_LEN = 20,
  parameter int HDR2_LEN = 8
) (
  input logic              clk,
  input logic              rst,
  fixed_deparser_if.master bus
);
  localparam int NH  = `NUM_HEADERS;
  localparam int OW  = `DATA_BUS + 1;          // one spare bit so off+len cannot wrap
  localparam int AIW = $clog2(`HDR_MAX_LEN);
  localparam int SW  = $clog2(NH);

  // STATE_SKIP stands in for the emit phase of a zero-byte packet so that
  // done_o still lands two cycles after the accepted start.
  typedef enum logic [1:0] {
    STATE_FREE,
    STATE_EMIT,
    STATE_SKIP,
    STATE_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0] hdr_reg;
  logic [NH-1:0][`DATA_BUS-1:0]           off_reg;
  logic [NH-1:0]                          present_reg;
  logic [NH-1:0]                          in_present;
  logic [NH-1:0]                          in_oob;
  logic [SW-1:0]                          slot_reg, slot_next;
  logic [SW-1:0]                          first_slot, next_slot;
  logic [OW-1:0]                          idx_reg, idx_next;
  logic [OW-1:0]                          cur_len;
  logic [AIW-1:0]                         addr;
  logic                                   err_reg, err_next;
  logic                                   load;
  logic                                   next_found;
  logic                                   at_end;

  function automatic logic [OW-1:0] slot_len(input int k);
    case (k)
      0:       slot_len = OW'(HDR0_LEN);
      1:       slot_len = OW'(HDR1_LEN);
      default: slot_len = OW'(HDR2_LEN);
    endcase
  endfunction

  // Per-slot presence and bound check on the incoming offsets.
  genvar gi;
  generate
    for (gi = 0; gi < NH; gi++) begin : g_eval
      logic          named;
      logic [OW-1:0] end_pos;
      assign named          = (bus.hdrs_i[gi] != `NO_HEADER);
      assign end_pos        = {1'b0, bus.hdrs_i[gi]} + slot_len(gi);
      assign in_present[gi] = named && (end_pos <= OW'(`HDR_MAX_LEN));
      assign in_oob[gi]     = named && (end_pos >  OW'(`HDR_MAX_LEN));
    end
  endgenerate

  // Lowest present incoming slot, and the next latched present slot above the current one.
  always_comb begin
    first_slot = '0;
    next_slot  = slot_reg;
    next_found = 1'b0;
    for (int k = NH - 1; k >= 0; k--) begin
      if (in_present[k]) begin
        first_slot = SW'(k);
      end
      if (present_reg[k] && (k > int'(slot_reg))) begin
        next_slot  = SW'(k);
        next_found = 1'b1;
      end
    end
  end

  // Present slots are always in bounds, so the truncated address is exact.
  assign cur_len = slot_len(int'(slot_reg));
  assign at_end  = (idx_reg == (cur_len - OW'(1)));
  assign addr    = AIW'(off_reg[slot_reg]) + AIW'(idx_reg);

  // Next-state and per-packet register updates.
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    idx_next   = idx_reg;
    err_next   = err_reg;
    load       = 1'b0;
    case (state_reg)
      STATE_FREE: begin
        if (bus.start_i) begin
          load       = 1'b1;
          err_next   = |in_oob;
          slot_next  = first_slot;
          idx_next   = '0;
          state_next = (|in_present) ? STATE_EMIT : STATE_SKIP;
        end
      end
      STATE_EMIT: begin
        if (bus.ready_i) begin
          if (at_end) begin
            if (next_found) begin
              slot_next = next_slot;
              idx_next  = '0;
            end else begin
              state_next = STATE_DONE;
            end
          end else begin
            idx_next = idx_reg + OW'(1);
          end
        end
      end
      STATE_SKIP: state_next = STATE_DONE;
      STATE_DONE: state_next = STATE_FREE;
      default:    state_next = STATE_FREE;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= STATE_FREE;
      slot_reg    <= '0;
      idx_reg     <= '0;
      err_reg     <= `FALSE;
      off_reg     <= '0;
      present_reg <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      idx_reg   <= idx_next;
      err_reg   <= err_next;
      if (load) begin
        off_reg     <= bus.hdrs_i;
        present_reg <= in_present;
      end
    end
  end

  // Header capture; contents only matter once a packet is accepted.
  always_ff @(posedge clk) begin
    if (load) begin
      hdr_reg <= bus.pkt_hdr_i;
    end
  end

  // Outputs decode from registers only, so they hold steady through stalls.
  assign bus.valid_o = (state_reg == STATE_EMIT);
  assign bus.byte_o  = bus.valid_o ? hdr_reg[addr] : '0;
  assign bus.last_o  = bus.valid_o && at_end && !next_found;
  assign bus.busy_o  = (state_reg == STATE_EMIT) || (state_reg == STATE_SKIP);
  assign bus.done_o  = (state_reg == STATE_DONE);
  assign bus.err_o   = err_reg;
endmodule

// File: tb/tb_fixed_deparser.sv
// Directed bench for the fixed header deparser.
module tb_fixed_deparser;
  localparam logic [7:0] NOH  = 8'hFF;
  localparam int         MAXL = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fixed_deparser_if bus ();
  fixed_deparser dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pkt_mem [MAXL];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int last_cnt, last_idx, last_cyc, done_cyc, stall_viol, first_valid, valid_cnt;
  logic busy_at1, err_at1, err_at_done, busy_at_done;

  // Load a header array with a seeded pattern and build the expected stream.
  task automatic load_pkt(input int seed, input logic [7:0] o0, input logic [7:0] o1,
                          input logic [7:0] o2);
    logic [7:0] offs [3];
    int lens [3];
    offs = '{o0, o1, o2};
    lens = '{14, 20, 8};
    for (int j = 0; j < MAXL; j++) begin
      pkt_mem[j]       = 8'((j * 7 + seed) & 255);
      bus.pkt_hdr_i[j] = pkt_mem[j];
    end
    bus.hdrs_i[0] = o0;
    bus.hdrs_i[1] = o1;
    bus.hdrs_i[2] = o2;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      if (offs[k] != NOH && (int'(offs[k]) + lens[k]) <= MAXL) begin
        for (int i = 0; i < lens[k]; i++) exp_q.push_back(pkt_mem[int'(offs[k]) + i]);
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // Observe the stream from the first cycle after start until done_o or the budget.
  // rmode 0: ready always high; rmode 1: ready 1,0,0 repeating.
  task automatic collect(input int rmode, input int mid_start, input int max_cyc);
    logic prev_stall;
    logic [7:0] pb;
    logic pl, rdy;
    got_q.delete();
    last_cnt = 0; last_idx = -1; last_cyc = -1; done_cyc = -1;
    stall_viol = 0; first_valid = -1; valid_cnt = 0;
    prev_stall = 1'b0; pb = '0; pl = 1'b0;
    busy_at1 = 1'b0; err_at1 = 1'b0; err_at_done = 1'b0; busy_at_done = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      rdy = (rmode == 0) ? 1'b1 : ((c % 3) == 1);
      bus.ready_i = rdy;
      bus.start_i = (c == mid_start);
      if (c == mid_start) begin
        bus.hdrs_i    = '0;
        bus.pkt_hdr_i = ~bus.pkt_hdr_i;
      end
      if (c == 1) begin
        busy_at1 = bus.busy_o;
        err_at1  = bus.err_o;
      end
      if (prev_stall && (!bus.valid_o || bus.byte_o !== pb || bus.last_o !== pl))
        stall_viol++;
      if (bus.valid_o) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = c;
      end
      if (bus.valid_o && rdy) begin
        got_q.push_back(bus.byte_o);
        if (bus.last_o) begin
          last_cnt++;
          last_idx = got_q.size() - 1;
          last_cyc = c;
        end
      end
      prev_stall = bus.valid_o && !rdy;
      pb = bus.byte_o;
      pl = bus.last_o;
      if (bus.done_o) begin
        done_cyc     = c;
        err_at_done  = bus.err_o;
        busy_at_done = bus.busy_o;
        break;
      end
      @(negedge clk);
    end
    bus.ready_i = 1'b1;
    bus.start_i = 1'b0;
  endtask

  function automatic int stream_bad();
    int bad;
    bad = 0;
    if (got_q.size() != exp_q.size()) return -1;
    for (int j = 0; j < got_q.size(); j++) if (got_q[j] !== exp_q[j]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    logic [9:0] obs;
    rst = 1'b1;
    bus.start_i = 1'b1;
    repeat (3) @(negedge clk);
    obs = {bus.byte_o, bus.valid_o, bus.last_o};
    n_checks++; if (obs !== 10'd0) begin n_fail++; $display("FAIL reset_stream got=%h want=0", obs); end
    n_checks++; if ({bus.busy_o, bus.done_o, bus.err_o} !== 3'b000) begin n_fail++;
      $display("FAIL reset_ctrl got=%b want=000", {bus.busy_o, bus.done_o, bus.err_o}); end
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    $display("reset: outputs idle");
  endtask

  task automatic test_ipv4();
    load_pkt(3, 8'd0, 8'd14, NOH);
    pulse_start();
    collect(0, 0, 60);
    n_checks++; if (got_q.size() !== 34) begin n_fail++; $display("FAIL ipv4_count got=%0d want=34", got_q.size()); end
    n_checks++; if (stream_bad() !== 0) begin n_fail++; $display("FAIL ipv4_bytes bad=%0d want=0", stream_bad()); end
    n_checks++; if (first_valid !== 1) begin n_fail++; $display("FAIL ipv4_first got=%0d want=1", first_valid); end
    n_checks++; if (valid_cnt !== 34) begin n_fail++; $display("FAIL ipv4_valid got=%0d want=34", valid_cnt); end
    n_checks++; if (last_cnt !== 1 || last_cyc !== 34) begin n_fail++;
      $display("FAIL ipv4_last cnt=%0d cyc=%0d want 1/34", last_cnt, last_cyc); end
    n_checks++; if (done_cyc !== 35) begin n_fail++; $display("FAIL ipv4_done got=%0d want=35", done_cyc); end
    n_checks++; if (busy_at1 !== 1'b1 || busy_at_done !== 1'b0) begin n_fail++;
      $display("FAIL ipv4_busy at1=%b atdone=%b want 1/0", busy_at1, busy_at_done); end
    $display("ipv4: %0d bytes, done at +%0d", got_q.size(), done_cyc);
  endtask

  task automatic test_non_ip();
    load_pkt(8'h40, 8'd0, NOH, NOH);
    pulse_start();
    collect(0, 0, 40);
    n_checks++; if (got_q.size() !== 14 || stream_bad() !== 0) begin n_fail++;
      $display("FAIL nonip_bytes size=%0d bad=%0d want 14/0", got_q.size(), stream_bad()); end
    n_checks++; if (last_idx !== 13 || last_cyc !== 14) begin n_fail++;
      $display("FAIL nonip_last idx=%0d cyc=%0d want 13/14", last_idx, last_cyc); end
    n_checks++; if (err_at_done !== 1'b0 || done_cyc !== 15) begin n_fail++;
      $display("FAIL nonip_done err=%b cyc=%0d want 0/15", err_at_done, done_cyc); end
    $display("non_ip: %0d bytes", got_q.size());
  endtask

  task automatic test_backpressure();
    load_pkt(8'h11, 8'd0, 8'd14, 8'd34);
    pulse_start();
    collect(1, 0, 200);
    n_checks++; if (got_q.size() !== 42 || stream_bad() !== 0) begin n_fail++;
      $display("FAIL bp_bytes size=%0d bad=%0d want 42/0", got_q.size(), stream_bad()); end
    n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stable got=%0d want=0", stall_viol); end
    n_checks++; if (last_idx !== 41 || last_cyc !== 124) begin n_fail++;
      $display("FAIL bp_last idx=%0d cyc=%0d want 41/124", last_idx, last_cyc); end
    n_checks++; if (done_cyc !== 125) begin n_fail++; $display("FAIL bp_done got=%0d want=125", done_cyc); end
    $display("backpressure: %0d bytes, done at +%0d", got_q.size(), done_cyc);
  endtask

  task automatic test_out_of_bounds();
    load_pkt(8'h22, 8'd0, 8'd54, NOH);
    pulse_start();
    collect(0, 0, 40);
    n_checks++; if (got_q.size() !== 14 || stream_bad() !== 0) begin n_fail++;
      $display("FAIL oob_bytes size=%0d bad=%0d want 14/0", got_q.size(), stream_bad()); end
    n_checks++; if (err_at1 !== 1'b1 || err_at_done !== 1'b1) begin n_fail++;
      $display("FAIL oob_err at1=%b atdone=%b want 1/1", err_at1, err_at_done); end
    @(negedge clk);
    n_checks++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL oob_err_hold got=%b want=1", bus.err_o); end
    load_pkt(8'h23, 8'd0, NOH, NOH);
    pulse_start();
    collect(0, 0, 40);
    n_checks++; if (err_at1 !== 1'b0 || got_q.size() !== 14) begin n_fail++;
      $display("FAIL oob_err_clear err=%b size=%0d want 0/14", err_at1, got_q.size()); end
    $display("out_of_bounds: err set then cleared");
  endtask

  task automatic test_boundary();
    load_pkt(5, NOH, NOH, 8'd56);
    pulse_start();
    collect(0, 0, 30);
    n_checks++; if (got_q.size() !== 8 || stream_bad() !== 0 || err_at_done !== 1'b0) begin n_fail++;
      $display("FAIL edge56 size=%0d bad=%0d err=%b want 8/0/0", got_q.size(), stream_bad(), err_at_done); end
    n_checks++; if (done_cyc !== 9) begin n_fail++; $display("FAIL edge56_done got=%0d want=9", done_cyc); end
    load_pkt(6, NOH, NOH, 8'd57);
    pulse_start();
    collect(0, 0, 30);
    n_checks++; if (valid_cnt !== 0 || err_at_done !== 1'b1 || done_cyc !== 2) begin n_fail++;
      $display("FAIL edge57 valid=%0d err=%b done=%0d want 0/1/2", valid_cnt, err_at_done, done_cyc); end
    load_pkt(7, 8'd0, NOH, 8'd14);
    pulse_start();
    collect(0, 0, 40);
    n_checks++; if (got_q.size() !== 22 || stream_bad() !== 0 || last_cyc !== 22) begin n_fail++;
      $display("FAIL gap size=%0d bad=%0d last=%0d want 22/0/22", got_q.size(), stream_bad(), last_cyc); end
    $display("boundary: offset 56 fits, 57 skipped, slot gap no bubble");
  endtask

  task automatic test_overlap();
    load_pkt(8'h5A, 8'd4, 8'd0, 8'd30);
    pulse_start();
    collect(0, 0, 60);
    n_checks++; if (got_q.size() !== 42 || stream_bad() !== 0 || done_cyc !== 43) begin n_fail++;
      $display("FAIL overlap size=%0d bad=%0d done=%0d want 42/0/43", got_q.size(), stream_bad(), done_cyc); end
    $display("overlap: %0d bytes", got_q.size());
  endtask

  task automatic test_empty();
    load_pkt(1, NOH, NOH, NOH);
    pulse_start();
    collect(0, 0, 20);
    n_checks++; if (valid_cnt !== 0 || got_q.size() !== 0) begin n_fail++;
      $display("FAIL empty_valid got=%0d want=0", valid_cnt); end
    n_checks++; if (done_cyc !== 2 || busy_at1 !== 1'b1 || err_at_done !== 1'b0) begin n_fail++;
      $display("FAIL empty_done cyc=%0d busy=%b err=%b want 2/1/0", done_cyc, busy_at1, err_at_done); end
    $display("empty: done at +%0d", done_cyc);
  endtask

  task automatic test_mid_start();
    load_pkt(9, 8'd0, 8'd14, NOH);
    pulse_start();
    collect(0, 10, 60);
    n_checks++; if (got_q.size() !== 34 || stream_bad() !== 0 || done_cyc !== 35) begin n_fail++;
      $display("FAIL midstart size=%0d bad=%0d done=%0d want 34/0/35", got_q.size(), stream_bad(), done_cyc); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_fail++;
      $display("FAIL midstart_queued valid=%b busy=%b want 0/0", bus.valid_o, bus.busy_o); end
    $display("mid_start: ignored");
  endtask

  task automatic test_back_to_back();
    load_pkt(8'h61, 8'd0, NOH, NOH);
    pulse_start();
    collect(0, 0, 40);
    load_pkt(8'h62, 8'd0, NOH, NOH);
    pulse_start();
    collect(0, 0, 40);
    n_checks++; if (first_valid !== 1 || got_q.size() !== 14 || stream_bad() !== 0) begin n_fail++;
      $display("FAIL b2b first=%0d size=%0d bad=%0d want 1/14/0", first_valid, got_q.size(), stream_bad()); end
    $display("back_to_back: second packet accepted after done");
  endtask

  task automatic test_reset_mid();
    int bad, dones;
    load_pkt(8'h30, 8'd0, 8'd54, NOH);
    pulse_start();
    bad = 0;
    for (int c = 1; c <= 5; c++) begin
      if (!bus.valid_o || bus.byte_o !== pkt_mem[c - 1]) bad++;
      if (c < 5) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_pre bad=%0d want=0", bad); end
    n_checks++; if ({bus.byte_o, bus.valid_o, bus.last_o, bus.busy_o, bus.done_o, bus.err_o} !== 13'd0) begin
      n_fail++; $display("FAIL rstmid_out got=%h want=0",
                         {bus.byte_o, bus.valid_o, bus.last_o, bus.busy_o, bus.done_o, bus.err_o}); end
    rst = 1'b0;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done_o || bus.valid_o) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_nodone got=%0d want=0", dones); end
    load_pkt(8'h55, 8'd0, 8'd14, NOH);
    pulse_start();
    collect(0, 0, 60);
    n_checks++; if (got_q.size() !== 34 || stream_bad() !== 0 || got_q[0] !== pkt_mem[0]) begin n_fail++;
      $display("FAIL rstmid_new size=%0d bad=%0d want 34/0", got_q.size(), stream_bad()); end
    $display("reset_mid: abandoned, restart from byte 0");
  endtask

  initial begin
    bus.start_i   = 1'b0;
    bus.ready_i   = 1'b1;
    bus.pkt_hdr_i = '0;
    bus.hdrs_i    = '1;
    test_reset();
    test_ipv4();
    test_non_ip();
    test_backpressure();
    test_out_of_bounds();
    test_boundary();
    test_overlap();
    test_empty();
    test_mid_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
